// File: rtl/gamma_lut_ctrl.sv
// rtl/gamma_lut_ctrl.sv - frame-synchronous double-buffered gamma LUT with runtime reload
//
// Ports:
//   I_CLK, I_Rst_n                      pixel clock, async active-low reset
//   Pre_Data, I_De, I_V_Sync, I_H_Sync  input pixel component and timing
//   Post_Data, O_De, O_V_Sync, O_H_Sync corrected pixel and timing, 2-cycle latency
//   I_Bypass                            force passthrough
//   I_Load_Start                        pulse: begin loading a new curve into the shadow bank
//   I_Wr_Valid, I_Wr_Data, O_Wr_Ready   loader entry stream, entries in address order 0..255
//   O_Busy                              loader FSM not idle
//   O_Swap_Done                         one-cycle pulse when the new curve becomes active
module gamma_lut_ctrl #(
    parameter int LUT_DEPTH = 256
) (
    input  logic       I_CLK,
    input  logic       I_Rst_n,
    input  logic [7:0] Pre_Data,
    input  logic       I_De,
    input  logic       I_V_Sync,
    input  logic       I_H_Sync,
    output logic [7:0] Post_Data,
    output logic       O_De,
    output logic       O_V_Sync,
    output logic       O_H_Sync,
    input  logic       I_Bypass,
    input  logic       I_Load_Start,
    input  logic       I_Wr_Valid,
    input  logic [7:0] I_Wr_Data,
    output logic       O_Wr_Ready,
    output logic       O_Busy,
    output logic       O_Swap_Done
);

    localparam int ADDR_W = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ARMED = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_wr_idx;
    logic                r_act_bank;
    logic                r_tbl_valid;
    logic                r_vs_q;

    logic                w_wr_ready;
    logic                w_busy;
    logic                w_swap_done;
    logic                w_wr_fire;
    logic                w_vs_rise;
    logic                w_last_entry;

    // Two banks of LUT_DEPTH entries; address = {bank, index}
    logic [7:0]          r_mem [0:2*LUT_DEPTH-1];

    logic [7:0]          r_ram_q;
    logic [7:0]          r_pre_q;
    logic                r_byp_q;
    logic [7:0]          r_post_data;
    logic [1:0]          r_de_pipe;
    logic [1:0]          r_vs_pipe;
    logic [1:0]          r_hs_pipe;

    assign w_wr_fire    = I_Wr_Valid && w_wr_ready;
    assign w_vs_rise    = I_V_Sync && !r_vs_q;
    assign w_last_entry = (r_wr_idx == ADDR_W'(LUT_DEPTH - 1));

    // ------------------------------------------------------------------
    // Loader FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Loader FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (I_Load_Start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_wr_fire && w_last_entry) begin
                    w_next_state = S_ARMED;
                end
            end
            S_ARMED: begin
                // Only an edge seen while armed counts, so an edge coinciding
                // with the last entry waits for the next frame.
                if (w_vs_rise) begin
                    w_next_state = S_SWAP;
                end
            end
            S_SWAP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Loader FSM: outputs
    always_comb begin
        w_wr_ready  = 1'b0;
        w_busy      = 1'b1;
        w_swap_done = 1'b0;
        case (r_state)
            S_IDLE:  w_busy      = 1'b0;
            S_LOAD:  w_wr_ready  = 1'b1;
            S_ARMED: w_wr_ready  = 1'b0;
            S_SWAP:  w_swap_done = 1'b1;
            default: w_busy      = 1'b0;
        endcase
    end

    assign O_Wr_Ready  = w_wr_ready;
    assign O_Busy      = w_busy;
    assign O_Swap_Done = w_swap_done;

    // ------------------------------------------------------------------
    // Loader bookkeeping and bank selection
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_wr_idx    <= '0;
            r_act_bank  <= 1'b0;
            r_tbl_valid <= 1'b0;
            r_vs_q      <= 1'b0;
        end else begin
            r_vs_q <= I_V_Sync;
            if (r_state == S_IDLE && I_Load_Start) begin
                r_wr_idx <= '0;
            end else if (w_wr_fire) begin
                // Wraps to 0 exactly as the FSM leaves LOAD
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (r_state == S_SWAP) begin
                r_act_bank  <= ~r_act_bank;
                r_tbl_valid <= 1'b1;
            end
        end
    end

    // Shadow-bank writes; contents survive reset on purpose
    always_ff @(posedge I_CLK) begin
        if (w_wr_fire) begin
            r_mem[{~r_act_bank, r_wr_idx}] <= I_Wr_Data;
        end
    end

    // ------------------------------------------------------------------
    // Pixel path, two stages
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_ram_q     <= '0;
            r_pre_q     <= '0;
            r_byp_q     <= 1'b0;
            r_post_data <= '0;
            r_de_pipe   <= '0;
            r_vs_pipe   <= '0;
            r_hs_pipe   <= '0;
        end else begin
            // Stage 1: bank sampled here, so a pixel never straddles a swap
            r_ram_q     <= r_mem[{r_act_bank, Pre_Data[ADDR_W-1:0]}];
            r_pre_q     <= Pre_Data;
            r_byp_q     <= I_Bypass || !r_tbl_valid;
            // Stage 2
            r_post_data <= r_byp_q ? r_pre_q : r_ram_q;
            r_de_pipe   <= {r_de_pipe[0], I_De};
            r_vs_pipe   <= {r_vs_pipe[0], I_V_Sync};
            r_hs_pipe   <= {r_hs_pipe[0], I_H_Sync};
        end
    end

    assign Post_Data = r_post_data;
    assign O_De      = r_de_pipe[1];
    assign O_V_Sync  = r_vs_pipe[1];
    assign O_H_Sync  = r_hs_pipe[1];

endmodule
